// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU: single-cycle logic/add/sub ops, iterative shift-add multiply
// and restoring divide, with a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; single-cycle results are registered on accept
// CALC  | one multiply/divide iteration per cycle, WIDTH iterations
// DONE  | one-cycle result-valid pulse, then back to IDLE
module ula_multiciclo #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       ulaOP,
    input  logic [WIDTH-1:0] RS,
    input  logic [WIDTH-1:0] RT,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] saidaULA,
    output logic [WIDTH-1:0] saidaHI,
    output logic [WIDTH-1:0] saidaLO,
    output logic             div_zero
);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_MUL  = 5'b00010;
    localparam logic [4:0] OP_DIV  = 5'b00011;
    localparam logic [4:0] OP_REM  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b00101;
    localparam logic [4:0] OP_AND  = 5'b00110;
    localparam logic [4:0] OP_NOT  = 5'b00111;
    localparam logic [4:0] OP_XOR  = 5'b01000;
    localparam logic [4:0] OP_NOR  = 5'b01001;
    localparam logic [4:0] OP_NAND = 5'b01010;
    localparam logic [4:0] OP_XNOR = 5'b01011;
    localparam logic [4:0] OP_GT   = 5'b01110;
    localparam logic [4:0] OP_PASS = 5'b11111;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, state_nx;
    logic [4:0]        op_r;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  acc_hi;
    logic [WIDTH-1:0]  acc_lo;
    logic [CNTW-1:0]   cnt;

    logic              in_mul, in_dvr, rt_zero, last_iter;
    logic [WIDTH-1:0]  single_res;
    logic [WIDTH:0]    mul_sum;
    logic [WIDTH:0]    div_shift, div_diff;
    logic [WIDTH-1:0]  step_hi, step_lo;

    always_comb begin
        in_mul    = (ulaOP == OP_MUL);
        in_dvr    = (ulaOP == OP_DIV) || (ulaOP == OP_REM);
        rt_zero   = (RT == '0);
        last_iter = (cnt == CNTW'(WIDTH - 1));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = (in_mul || (in_dvr && !rt_zero)) ? CALC : DONE;
            CALC: if (last_iter) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        busy = (state == CALC);
        done = (state == DONE);
    end

    always_comb begin
        single_res = '0;
        case (ulaOP)
            OP_ADD:  single_res = RS + RT;
            OP_SUB:  single_res = RS - RT;
            OP_OR:   single_res = RS | RT;
            OP_AND:  single_res = RS & RT;
            OP_NOT:  single_res = ~RS;
            OP_XOR:  single_res = RS ^ RT;
            OP_NOR:  single_res = ~(RS | RT);
            OP_NAND: single_res = ~(RS & RT);
            OP_XNOR: single_res = ~(RS ^ RT);
            OP_GT:   single_res = (RS > RT) ? WIDTH'(1) : '0;
            OP_PASS: single_res = RT;
            default: single_res = '0;
        endcase
    end

    // Multiply: {acc_hi, acc_lo} is the product/multiplier shift register.
    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in;
    // the partial remainder stays below the divisor, so the MSB of the W+1 bit difference is its sign.
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_r} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, a_r};
        if (op_r == OP_MUL) begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end else begin
            step_hi = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_r     <= '0;
            a_r      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            cnt      <= '0;
            saidaULA <= '0;
            saidaHI  <= '0;
            saidaLO  <= '0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_r   <= ulaOP;
                    cnt    <= '0;
                    acc_hi <= '0;
                    a_r    <= in_mul ? RS : RT;
                    acc_lo <= in_mul ? RT : RS;
                    if (in_dvr && rt_zero) begin
                        saidaULA <= (ulaOP == OP_REM) ? RS : '1;
                        saidaHI  <= RS;
                        saidaLO  <= '1;
                        div_zero <= 1'b1;
                    end else if (!in_mul && !in_dvr) begin
                        saidaULA <= single_res;
                        div_zero <= 1'b0;
                    end
                end
                CALC: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + 1'b1;
                    if (last_iter) begin
                        saidaHI  <= step_hi;
                        saidaLO  <= step_lo;
                        saidaULA <= (op_r == OP_REM) ? step_hi : step_lo;
                        div_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ula_multiciclo.sv
// Directed bench for ula_multiciclo: vector table plus reset-abort and start-spam sequences.
module tb_ula_multiciclo;

    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [4:0]    ulaOP = '0;
    logic [W-1:0]  RS = '0, RT = '0;
    logic          busy, done, div_zero;
    logic [W-1:0]  saidaULA, saidaHI, saidaLO;

    ula_multiciclo #(.WIDTH(W), .CNTW(6)) dut (
        .clock(clock), .reset(reset), .start(start), .ulaOP(ulaOP),
        .RS(RS), .RT(RT), .busy(busy), .done(done),
        .saidaULA(saidaULA), .saidaHI(saidaHI), .saidaLO(saidaLO),
        .div_zero(div_zero)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] ula;
        logic         dz;
        logic         upd;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           lat;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int failures = 0;
    logic [W-1:0] m_hi = '0, m_lo = '0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Launch one op and wait for done; lat = cycle index of done after accept (0 on timeout).
    task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int nbusy, output logic busy_at_done);
        lat = 0; nbusy = 0; busy_at_done = 1'b0;
        @(negedge clock);
        start = 1'b1; ulaOP = op; RS = a; RT = b;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clock);
            if (n == 1) begin
                start = 1'b0; RS = $urandom; RT = $urandom; ulaOP = 5'b00000;
            end
            if (done) begin
                lat = n; busy_at_done = busy;
                break;
            end
            if (busy) nbusy++;
        end
    endtask

    initial begin
        int lat, nbusy, ndone, dlat;
        logic bad;
        logic [W-1:0] c_ula, c_hi, c_lo;
        string nm;

        vecs.push_back('{5'b00000, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0, 1'b0, 32'h0, 32'h0, 1});
        vecs.push_back('{5'b00001, 32'h5,        32'h7,        32'hFFFFFFFE, 1'b0, 1'b0, 32'h0, 32'h0, 1});
        vecs.push_back('{5'b00010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        1'b0, 1'b1, 32'hFFFFFFFE, 32'h1, 33});
        vecs.push_back('{5'b00101, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0, 32'h0, 32'h0, 1});
        vecs.push_back('{5'b01010, 32'hFFFFFFFF, 32'h0,        32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 32'h0, 1});
        vecs.push_back('{5'b00011, 32'd100,      32'd7,        32'd14,       1'b0, 1'b1, 32'd2, 32'd14, 33});
        vecs.push_back('{5'b00100, 32'd100,      32'd7,        32'd2,        1'b0, 1'b1, 32'd2, 32'd14, 33});
        vecs.push_back('{5'b00011, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 1'b1, 32'd5, 32'hFFFFFFFF, 1});
        vecs.push_back('{5'b00100, 32'd5,        32'd0,        32'd5,        1'b1, 1'b1, 32'd5, 32'hFFFFFFFF, 1});
        vecs.push_back('{5'b00110, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 32'h0, 32'h0, 1});
        vecs.push_back('{5'b00111, 32'h12345678, 32'h0,        32'hEDCBA987, 1'b0, 1'b0, 32'h0, 32'h0, 1});
        vecs.push_back('{5'b01000, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, 1'b0, 32'h0, 32'h0, 1});
        vecs.push_back('{5'b01001, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h0,        1'b0, 1'b0, 32'h0, 32'h0, 1});
        vecs.push_back('{5'b01011, 32'h12345678, 32'h12345678, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, 32'h0, 1});
        vecs.push_back('{5'b01110, 32'h80000000, 32'h7FFFFFFF, 32'h1,        1'b0, 1'b0, 32'h0, 32'h0, 1});
        vecs.push_back('{5'b01110, 32'h5,        32'h5,        32'h0,        1'b0, 1'b0, 32'h0, 32'h0, 1});
        vecs.push_back('{5'b01100, 32'h12345678, 32'h9ABCDEF0, 32'h0,        1'b0, 1'b0, 32'h0, 32'h0, 1});
        vecs.push_back('{5'b00010, 32'h00012345, 32'h00000100, 32'h01234500, 1'b0, 1'b1, 32'h0, 32'h01234500, 33});
        vecs.push_back('{5'b00010, 32'h00010000, 32'h00010000, 32'h0,        1'b0, 1'b1, 32'h1, 32'h0, 33});
        vecs.push_back('{5'b00010, 32'h0,        32'h5,        32'h0,        1'b0, 1'b1, 32'h0, 32'h0, 33});
        vecs.push_back('{5'b00011, 32'd7,        32'd100,      32'd0,        1'b0, 1'b1, 32'd7, 32'd0, 33});
        vecs.push_back('{5'b00011, 32'hFFFFFFFF, 32'h1,        32'hFFFFFFFF, 1'b0, 1'b1, 32'h0, 32'hFFFFFFFF, 33});
        vecs.push_back('{5'b11111, 32'h11111111, 32'hCAFEBABE, 32'hCAFEBABE, 1'b0, 1'b0, 32'h0, 32'h0, 1});

        #12;
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_done", {31'b0, done}, 32'h0);
        check("reset_ula", saidaULA, 32'h0);
        check("reset_hi", saidaHI, 32'h0);
        check("reset_lo", saidaLO, 32'h0);
        check("reset_dz", {31'b0, div_zero}, 32'h0);
        @(negedge clock);
        reset = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, nbusy, bad);
            if (vecs[i].upd) begin m_hi = vecs[i].hi; m_lo = vecs[i].lo; end
            nm = $sformatf("v%0d_op%b", i, vecs[i].op);
            check({nm, "_lat"}, lat, vecs[i].lat);
            check({nm, "_busycycles"}, nbusy, vecs[i].lat - 1);
            check({nm, "_busy_at_done"}, {31'b0, bad}, 32'h0);
            check({nm, "_ula"}, saidaULA, vecs[i].ula);
            check({nm, "_hi"}, saidaHI, m_hi);
            check({nm, "_lo"}, saidaLO, m_lo);
            check({nm, "_dz"}, {31'b0, div_zero}, {31'b0, vecs[i].dz});
        end

        // Asynchronous reset in the middle of a multiply.
        @(negedge clock);
        start = 1'b1; ulaOP = 5'b00010; RS = 32'hFFFFFFFF; RT = 32'h3;
        @(negedge clock);
        start = 1'b0;
        repeat (8) @(negedge clock);
        check("abort_busy_before", {31'b0, busy}, 32'h1);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_done", {31'b0, done}, 32'h0);
        check("abort_ula", saidaULA, 32'h0);
        check("abort_hi", saidaHI, 32'h0);
        check("abort_lo", saidaLO, 32'h0);
        check("abort_dz", {31'b0, div_zero}, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        m_hi = '0; m_lo = '0;
        run_op(5'b00000, 32'd2, 32'd3, lat, nbusy, bad);
        check("post_reset_lat", lat, 1);
        check("post_reset_ula", saidaULA, 32'd5);
        check("post_reset_hi", saidaHI, 32'h0);

        // start held high for the whole divide with changing operands; only one result.
        ndone = 0; dlat = 0; c_ula = '0; c_hi = '0; c_lo = '0;
        @(negedge clock);
        start = 1'b1; ulaOP = 5'b00011; RS = 32'd100; RT = 32'd7;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clock);
            ulaOP = 5'b00000; RS = 32'd1; RT = 32'd1;
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    dlat = n; c_ula = saidaULA; c_hi = saidaHI; c_lo = saidaLO;
                    start = 1'b0;
                end
            end
        end
        check("spam_done_count", ndone, 1);
        check("spam_lat", dlat, 33);
        check("spam_ula", c_ula, 32'd14);
        check("spam_hi", c_hi, 32'd2);
        check("spam_lo", c_lo, 32'd14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
